// File: rtl/sol_rom_pkg.sv
// Shared types and region map for the Solomon ROM download sequencer.
// Regions are indexed 0..3: main CPU, sound CPU, tiles, sprites.
package sol_rom_pkg;

   localparam int unsigned NREG_SOL = 4;
   localparam int unsigned LAW_SOL  = 16;
   localparam int unsigned GAW_SOL  = 25;

   // Packed so element [0] is the rightmost constant in each list.
   localparam logic [NREG_SOL-1:0][GAW_SOL-1:0] REG_BASE =
      {25'h15000, 25'h0D000, 25'h0C000, 25'h00000};
   localparam logic [NREG_SOL-1:0][GAW_SOL-1:0] REG_SIZE =
      {25'h08000, 25'h08000, 25'h01000, 25'h0C000};

   typedef enum logic [2:0] {
      ST_WAIT,
      ST_LOAD,
      ST_DRAIN,
      ST_SETTLE,
      ST_RUN
   } state_t;

   typedef struct packed {
      logic [NREG_SOL-1:0] sel;
      logic [LAW_SOL-1:0]  lad;
      logic [7:0]          dat;
   } wr_ent_t;

endpackage

// File: rtl/rom_wr_fifo.sv
// Synchronous FIFO of ROM write entries; a push is accepted when full
// if a pop happens on the same edge.
module rom_wr_fifo
   import sol_rom_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)(
   input  logic    i_clk,
   input  logic    i_rst_n,
   input  logic    i_push,
   input  wr_ent_t i_din,
   input  logic    i_pop,
   output wr_ent_t o_dout,
   output logic    o_full,
   output logic    o_empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = 1;

   wr_ent_t     r_mem [DEPTH];
   logic [PW:0] r_wp;
   logic [PW:0] r_rp;
   logic        w_wen;
   logic        w_ren;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_empty = (r_wp == r_rp);
   assign o_full  = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
   assign w_ren   = i_pop & ~o_empty;
   assign w_wen   = i_push & (~o_full | w_ren);
   assign o_dout  = r_mem[r_rp[PW-1:0]];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_wen) r_wp <= r_wp + PTR_ONE;
         if (w_ren) r_rp <= r_rp + PTR_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wen) r_mem[r_wp[PW-1:0]] <= i_din;
   end

endmodule

// File: rtl/rom_load_sequencer.sv
// Routes the HPS ROM download stream into per-region ROM write ports and
// holds the core in reset until loading settles. ROM_CKSUM_EN adds CKSUM.
module rom_load_sequencer
   import sol_rom_pkg::*;
#(
   parameter int unsigned NREG       = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned SETTLE_CYC = 256,
   parameter int unsigned LAW        = 16
)(
   input  logic            MCLK,
   input  logic            RESET_N,
   input  logic            DLACT,
   input  logic            ROMEN,
   input  logic [24:0]     ROMAD,
   input  logic [7:0]      ROMDT,
   input  logic [NREG-1:0] WRDY,
   output logic [NREG-1:0] WE,
   output logic [LAW-1:0]  WAD,
   output logic [7:0]      WDT,
   output logic            CORE_RST,
   output logic            LOAD_DONE,
   output logic            ERR_OOR,
   output logic            ERR_OVF,
   output logic [15:0]     CKSUM
);

   localparam int unsigned CW = $clog2(SETTLE_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] CNT_ONE  = 1;

   state_t          r_state;
   state_t          w_nxt;
   logic [CW-1:0]   r_cnt;
   logic            r_dvld;
   wr_ent_t         r_dent;
   logic            r_oor;
   logic            r_ovf;

   logic            w_take;
   logic            w_hit;
   logic [NREG-1:0] w_sel;
   logic [LAW-1:0]  w_lad;
   logic            w_enter_load;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   wr_ent_t         w_head;

   assign w_take       = ROMEN && (r_state == ST_LOAD);
   assign w_enter_load = (w_nxt == ST_LOAD) && (r_state != ST_LOAD);
   assign w_pop        = |(WE & WRDY);

   // Lowest-index region wins when ranges overlap.
   always_comb begin
      w_hit = 1'b0;
      w_sel = '0;
      w_lad = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (!w_hit && (ROMAD >= REG_BASE[i]) && (ROMAD < REG_BASE[i] + REG_SIZE[i])) begin
            w_hit    = 1'b1;
            w_sel[i] = 1'b1;
            w_lad    = LAW'(ROMAD - REG_BASE[i]);
         end
      end
   end

   always_ff @(posedge MCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_dvld <= 1'b0;
         r_dent <= '0;
      end else begin
         r_dvld <= w_take & w_hit;
         if (w_take & w_hit) r_dent <= '{sel: w_sel, lad: w_lad, dat: ROMDT};
      end
   end

   rom_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (MCLK),
      .i_rst_n (RESET_N),
      .i_push  (r_dvld),
      .i_din   (r_dent),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign WE  = w_empty ? '0 : w_head.sel;
   assign WAD = w_empty ? '0 : w_head.lad;
   assign WDT = w_empty ? '0 : w_head.dat;

   always_ff @(posedge MCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= ST_WAIT;
         r_cnt   <= '0;
         r_oor   <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= ((r_state == ST_SETTLE) && (w_nxt == ST_SETTLE)) ? r_cnt + CNT_ONE : '0;
         if (w_enter_load) begin
            r_oor <= 1'b0;
            r_ovf <= 1'b0;
         end else begin
            if (w_take & ~w_hit)             r_oor <= 1'b1;
            if (r_dvld & w_full & ~w_pop)    r_ovf <= 1'b1;
         end
      end
   end

   always_comb begin
      w_nxt     = r_state;
      CORE_RST  = 1'b1;
      LOAD_DONE = 1'b0;
      unique case (r_state)
         ST_WAIT:   if (DLACT) w_nxt = ST_LOAD;
         ST_LOAD:   if (!DLACT) w_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (DLACT)                    w_nxt = ST_LOAD;
            else if (w_empty && !r_dvld)  w_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (DLACT)                    w_nxt = ST_LOAD;
            else if (r_cnt == CNT_LAST)   w_nxt = ST_RUN;
         end
         ST_RUN: begin
            CORE_RST  = 1'b0;
            LOAD_DONE = 1'b1;
            if (DLACT) w_nxt = ST_LOAD;
         end
         default:   w_nxt = ST_WAIT;
      endcase
   end

   assign ERR_OOR = r_oor;
   assign ERR_OVF = r_ovf;

`ifdef ROM_CKSUM_EN
   logic [15:0] r_cksum;

   always_ff @(posedge MCLK or negedge RESET_N) begin
      if (!RESET_N)                          r_cksum <= '0;
      else if (w_enter_load)                 r_cksum <= '0;
      else if (w_pop && (r_state != ST_RUN)) r_cksum <= r_cksum + {8'h00, WDT};
   end

   assign CKSUM = r_cksum;
`else
   assign CKSUM = '0;
`endif

endmodule
